// File: rtl/lsq_mem_arbiter_pkg.sv
// ============================================================================
// Module      : lsq_mem_arbiter_pkg
// Description : Shared types and constants for the LSQ data-cache port
//               arbiter: FSM state encoding, request record, queue depths,
//               store-starvation limit and committed-store watermark.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsq_mem_arbiter_pkg;

    localparam int LDQ_ENTRIES      = 16;
    localparam int SDQ_ENTRIES      = 16;
    localparam int STORE_STARVE_MAX = 8;
    localparam int SDQ_HIGH_WM      = 12;

    // Index width wide enough to address either queue.
    localparam int MEM_IDX_W = $clog2((LDQ_ENTRIES > SDQ_ENTRIES) ? LDQ_ENTRIES : SDQ_ENTRIES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 is_store;
        logic [MEM_IDX_W-1:0] idx;
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/lsq_mem_arbiter_age.sv
// ============================================================================
// Module      : age_picker
// Description : Rotating find-first. Returns the first set bit of elig at or
//               after head, wrapping modulo N (oldest eligible queue entry).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module age_picker #(
    parameter int  N = 16,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] head,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [W-1:0]   offset;
    logic [W:0]     sum;

    // Rotate so bit 0 corresponds to head, then find the lowest set bit.
    always_comb begin
        doubled = {elig, elig};
        rotated = N'(doubled >> head);
        found   = 1'b0;
        offset  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = W'(k);
            end
        end
    end

    // Map the offset back to an absolute index, wrapping past the last entry.
    always_comb begin
        sum = {1'b0, head} + {1'b0, offset};
        if (sum >= (W+1)'(N)) begin
            idx = W'(sum - (W+1)'(N));
        end else begin
            idx = W'(sum);
        end
    end

endmodule

`default_nettype wire

// File: rtl/lsq_mem_arbiter.sv
// ============================================================================
// Module      : lsq_mem_arbiter
// Description : Schedules the single D-cache port between the load queue and
//               the store data queue. Picks the oldest eligible entry of each,
//               arbitrates load vs store (watermark and starvation aware),
//               issues a valid/ready request and tracks one outstanding
//               access. Flush cancels speculative loads; stores always finish.
//               Optional macro LSQ_ARB_PERF_EN adds grant/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsq_mem_arbiter #(
    parameter int  LDQ_ENTRIES      = lsq_mem_arbiter_pkg::LDQ_ENTRIES,
    parameter int  SDQ_ENTRIES      = lsq_mem_arbiter_pkg::SDQ_ENTRIES,
    parameter int  STORE_STARVE_MAX = lsq_mem_arbiter_pkg::STORE_STARVE_MAX,
    parameter int  SDQ_HIGH_WM      = lsq_mem_arbiter_pkg::SDQ_HIGH_WM,
    localparam int LDQ_W            = (LDQ_ENTRIES > 1) ? $clog2(LDQ_ENTRIES) : 1,
    localparam int SDQ_W            = (SDQ_ENTRIES > 1) ? $clog2(SDQ_ENTRIES) : 1,
    localparam int IDX_W            = (LDQ_W > SDQ_W) ? LDQ_W : SDQ_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LDQ_ENTRIES-1:0] ldq_elig,
    input  logic [LDQ_W-1:0]       ldq_head,
    input  logic [SDQ_ENTRIES-1:0] sdq_elig,
    input  logic [SDQ_W-1:0]       sdq_head,
    input  logic [SDQ_W:0]         sdq_commit_cnt,
    input  logic                   flush,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_is_store,
    output logic [IDX_W-1:0]       mem_req_idx,
    output logic                   ldq_issue,
    output logic                   sdq_issue,
    input  logic                   mem_resp_valid,
    output logic                   ld_done_valid,
    output logic [LDQ_W-1:0]       ld_done_idx
`ifdef LSQ_ARB_PERF_EN
    ,
    output logic [31:0]            perf_ld_grants,
    output logic [31:0]            perf_st_grants,
    output logic [31:0]            perf_stall_cycles
`endif
);

    import lsq_mem_arbiter_pkg::*;

    localparam int STV_W = $clog2(STORE_STARVE_MAX + 1);

    arb_state_t       state, state_nxt;
    mem_req_t         req, req_nxt;
    logic [STV_W-1:0] starve, starve_nxt;

    logic             ld_found, st_found;
    logic [LDQ_W-1:0] ld_pick;
    logic [SDQ_W-1:0] st_pick;
    logic             st_urgent;
    logic             pick_store;

    age_picker #(.N(LDQ_ENTRIES)) u_ldq_pick (
        .elig  (ldq_elig),
        .head  (ldq_head),
        .found (ld_found),
        .idx   (ld_pick)
    );

    age_picker #(.N(SDQ_ENTRIES)) u_sdq_pick (
        .elig  (sdq_elig),
        .head  (sdq_head),
        .found (st_found),
        .idx   (st_pick)
    );

    // Store wins when the committed backlog is high or loads have starved it.
    always_comb begin
        st_urgent  = (int'(sdq_commit_cnt) >= SDQ_HIGH_WM) ||
                     (int'(starve) == STORE_STARVE_MAX);
        pick_store = st_found && (!ld_found || st_urgent);
    end

    // Next-state, request record, issue/done pulses and starvation tracking.
    always_comb begin
        state_nxt     = state;
        req_nxt       = req;
        starve_nxt    = starve;
        ldq_issue     = 1'b0;
        sdq_issue     = 1'b0;
        ld_done_valid = 1'b0;

        if (sdq_elig == '0) begin
            starve_nxt = '0;
        end

        case (state)
            IDLE: begin
                if (!flush && (ld_found || st_found)) begin
                    req_nxt.valid    = 1'b1;
                    req_nxt.is_store = pick_store;
                    req_nxt.idx      = pick_store ? MEM_IDX_W'(st_pick) : MEM_IDX_W'(ld_pick);
                    state_nxt        = REQ;
                    if (pick_store) begin
                        starve_nxt = '0;
                    end else if (st_found && (int'(starve) < STORE_STARVE_MAX)) begin
                        starve_nxt = starve + 1'b1;
                    end
                end
            end
            REQ: begin
                if (flush && !req.is_store) begin
                    // Speculative load cancelled; if the cache took it anyway,
                    // its response still has to be absorbed.
                    req_nxt.valid = 1'b0;
                    state_nxt     = mem_req_ready ? DRAIN : IDLE;
                end else if (mem_req_ready) begin
                    req_nxt.valid = 1'b0;
                    ldq_issue     = !req.is_store;
                    sdq_issue     = req.is_store;
                    state_nxt     = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    ld_done_valid = !req.is_store && !flush;
                    state_nxt     = IDLE;
                end else if (flush && !req.is_store) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_resp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, request record and starvation counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            req    <= '0;
            starve <= '0;
        end else begin
            state  <= state_nxt;
            req    <= req_nxt;
            starve <= starve_nxt;
        end
    end

    // Request and completion outputs come straight from the registered record.
    always_comb begin
        mem_req_valid    = req.valid;
        mem_req_is_store = req.is_store;
        mem_req_idx      = IDX_W'(req.idx);
        ld_done_idx      = LDQ_W'(req.idx);
    end

`ifdef LSQ_ARB_PERF_EN
    // Wrapping handshake and stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ld_grants    <= '0;
            perf_st_grants    <= '0;
            perf_stall_cycles <= '0;
        end else if (state == REQ) begin
            if (mem_req_ready && !req.is_store) begin
                perf_ld_grants <= perf_ld_grants + 32'd1;
            end
            if (mem_req_ready && req.is_store) begin
                perf_st_grants <= perf_st_grants + 32'd1;
            end
            if (!mem_req_ready) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
